// File: rtl/lattice_readout.sv
// Streams one lattice frame from a read-latency BRAM port onto an AXI4-Stream master.
// Optional header beat carrying the frame number: define LATTICE_READOUT_HEADER_EN.
module lattice_readout #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int READ_LAT = 2,
    parameter int FIFO_D   = READ_LAT + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       frame_count
);

    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int BEAT_W = $clog2(DEPTH + 2);
`ifdef LATTICE_READOUT_HEADER_EN
    localparam int LAST_BEAT = DEPTH;
`else
    localparam int LAST_BEAT = DEPTH - 1;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef LATTICE_READOUT_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_DRAIN, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [ADDR_W-1:0]   addr;
    logic [READ_LAT-1:0] rd_vld_p;
    logic [DATA_W-1:0]   fifo_mem [FIFO_D];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [BEAT_W-1:0]   beat_idx;
    logic [15:0]         frame_cnt;

    logic              issue;
    logic              credit_ok;
    logic              drain_empty;
    logic              hdr_push;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept = (state == S_IDLE) && start;

    // Every issued read owns a FIFO slot from issue until it is popped.
    assign credit_ok   = (int'(fifo_cnt) + $countones(rd_vld_p)) < FIFO_D;
    assign drain_empty = (rd_vld_p == '0) &&
                         ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

`ifdef LATTICE_READOUT_HEADER_EN
    assign hdr_push  = accept;
    assign push_data = hdr_push ? DATA_W'(frame_cnt) : bram_dout;
`else
    assign hdr_push  = 1'b0;
    assign push_data = bram_dout;
`endif

    assign push = rd_vld_p[READ_LAT-1] | hdr_push;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef LATTICE_READOUT_HEADER_EN
                    state_nxt = S_HEADER;
`else
                    state_nxt = S_READ;
`endif
                end
            end
`ifdef LATTICE_READOUT_HEADER_EN
            S_HEADER: state_nxt = S_READ;
`endif
            S_READ: begin
                issue = credit_ok;
                if (credit_ok && (addr == LAST_ADDR)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_empty) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            frame_cnt <= '0;
            beat_idx  <= '0;
        end else begin
            if (accept)
                addr <= '0;
            else if (issue && (addr != LAST_ADDR))
                addr <= addr + 1'b1;

            if (accept)   beat_idx <= '0;
            else if (pop) beat_idx <= beat_idx + 1'b1;

            if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Stage p0..p(READ_LAT-1): reads in flight; the last stage marks bram_dout valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_vld_p <= '0;
        else     rd_vld_p <= (rd_vld_p << 1) | READ_LAT'(issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    // Head is gated so tdata reads zero whenever nothing is offered.
    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat_idx == BEAT_W'(LAST_BEAT));

    assign bram_en     = issue;
    assign bram_addr   = addr;
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign frame_done  = (state == S_DONE);
    assign frame_count = frame_cnt;

endmodule

// File: tb/tb_lattice_readout.sv
// Randomized bench for lattice_readout against a queue-based frame model.
`timescale 1ns/1ps
module tb_lattice_readout;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 16;
    localparam int READ_LAT = 2;
    localparam int FIFO_D   = READ_LAT + 2;
`ifdef LATTICE_READOUT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              tready = 1'b1;
    logic              busy, frame_done, bram_en, tvalid, tlast;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout, tdata;
    logic [15:0]       frame_count;

    lattice_readout #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // BRAM model: data appears READ_LAT cycles after the enable is sampled.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe [READ_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= bram_en ? mem[bram_addr] : 16'hDEAD;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[READ_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
        logic              h;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       b;
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic [15:0] m_fc     = 16'd0;
    logic        force_fc = 1'b0;
    logic        done_now, next_done, hs, hold_prev = 1'b0;
    logic [DATA_W-1:0] prev_d;
    logic        prev_l;
    int cyc = 0;
    int rd_idx = 0, data_popped = 0, beats_seen = 0;
    int start_cyc = -1, first_en_cyc = -1, first_valid_cyc = -1;
    int first_data_cyc = -1, last_data_cyc = -1, done_cyc = -1;
    logic [DATA_W-1:0] first_data_val, last_data_val;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("reset_outputs",
                  {busy, frame_done, bram_addr, bram_en, tdata, tvalid, tlast, frame_count}, '0);
            exp_q.delete();
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_fc      = 16'd0;
            hold_prev = 1'b0;
            rd_idx    = 0;
        end else begin
            if (force_fc) m_fc = 16'hFFFF;
            done_now = m_done;
            check("frame_done", frame_done, done_now);
            check("busy", busy, m_active && !done_now);
            if (frame_done) done_cyc = cyc;
            if (!m_active) begin
                check("idle_frame_count", frame_count, m_fc);
                check("idle_tvalid", tvalid, 1'b0);
            end
            if (bram_en) begin
                check("read_in_frame", m_active && !done_now && (rd_idx < DEPTH), 1'b1);
                check("bram_addr", bram_addr, rd_idx);
                if (rd_idx == 0) first_en_cyc = cyc;
                rd_idx++;
                check("credit_bound", (rd_idx - data_popped) <= FIFO_D, 1'b1);
            end
            if (hold_prev) begin
                check("hold_tvalid", tvalid, 1'b1);
                check("hold_tdata", tdata, prev_d);
                check("hold_tlast", tlast, prev_l);
            end
            hs = tvalid && tready;
            next_done = 1'b0;
            if (tvalid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    b = exp_q[0];
                    check("tdata", tdata, b.d);
                    check("tlast", tlast, b.l);
                    if (hs) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                        if (!b.h) begin
                            data_popped++;
                            if (first_data_cyc < 0) begin
                                first_data_cyc = cyc;
                                first_data_val = tdata;
                            end
                            last_data_cyc = cyc;
                            last_data_val = tdata;
                        end
                        if (b.l) next_done = 1'b1;
                    end
                end
            end
            hold_prev = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;

            if (done_now) begin
                m_active = 1'b0;
                m_fc = m_fc + 16'd1;
            end
            m_done = next_done;
            if (start && !m_active) begin
                m_active = 1'b1;
                rd_idx = 0; data_popped = 0; beats_seen = 0;
                start_cyc = cyc; first_en_cyc = -1; first_valid_cyc = -1;
                first_data_cyc = -1; last_data_cyc = -1;
                if (HDR != 0) exp_q.push_back('{d: DATA_W'(m_fc), l: 1'b0, h: 1'b1});
                for (int i = 0; i < DEPTH; i++)
                    exp_q.push_back('{d: mem[i], l: (i == DEPTH - 1), h: 1'b0});
            end
        end
    end

    logic bp_on = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_on) tready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 2000 && m_active; n++) tick();
        check("frame_timeout", m_active, 1'b0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    endtask

    logic [15:0] fc0;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(16'h0100 + i);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Free-flowing frame with the ramp pattern
        pulse_start();
        wait_frame();
        tick();
        check("lat_first_en", first_en_cyc - start_cyc, (HDR != 0) ? 2 : 1);
        check("lat_first_tvalid", first_valid_cyc - start_cyc, (HDR != 0) ? 1 : READ_LAT + 2);
        check("data_span", last_data_cyc - first_data_cyc, DEPTH - 1);
        check("first_data", first_data_val, 16'h0100);
        check("last_data", last_data_val, 16'h010F);
        check("beat_total", beats_seen, DEPTH + HDR);
        check("done_after_tlast", done_cyc - last_data_cyc, 1);
        check("fc_first_frame", frame_count, 16'd1);

        // Reset mid-frame, after the fifth data beat
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("fc_after_idle_reset", frame_count, 16'd0);
        fill_random();
        pulse_start();
        for (int n = 0; n < 500 && data_popped < 5; n++) tick();
        check("beat5_reached", data_popped >= 5, 1'b1);
        rst = 1'b1;
        #2;
        check("rst_mid_outputs",
              {busy, frame_done, bram_addr, bram_en, tdata, tvalid, tlast, frame_count}, '0);
        tick();
        rst = 1'b0;
        tick();
        check("fc_unchanged", frame_count, 16'd0);
        pulse_start();
        wait_frame();
        tick();
        check("rerun_beats", beats_seen, DEPTH + HDR);
        check("fc_after_rerun", frame_count, 16'd1);

        // Random backpressure
        bp_on = 1'b1;
        repeat (2) begin
            fill_random();
            pulse_start();
            wait_frame();
        end
        bp_on = 1'b0;
        tready = 1'b1;
        tick();

        // Start pulses while busy are dropped
        fill_random();
        fc0 = frame_count;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        repeat (4) tick();
        pulse_start();
        wait_frame();
        tick();
        check("busy_start_beats", beats_seen, DEPTH + HDR);
        check("busy_start_fc", frame_count, 16'(fc0 + 16'd1));

        // Back-to-back frames
        repeat (3) begin
            fill_random();
            pulse_start();
            wait_frame();
        end
        tick();

        // Counter wrap
        #1;
        force dut.frame_cnt = 16'hFFFF;
        force_fc = 1'b1;
        tick();
        release dut.frame_cnt;
        force_fc = 1'b0;
        check("wrap_preload", frame_count, 16'hFFFF);
        pulse_start();
        wait_frame();
        tick();
        check("wrap", frame_count, 16'h0000);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lattice_readout.md
# lattice_readout

Reads one complete lattice frame out of a single-port direction BRAM after the solver has finished a step, and streams it to the host over an AXI4-Stream master with full backpressure support. It is the reader counterpart to the solver's BRAM write path. It sits between the lattice BRAM read port (muxed to it while the solver is idle) and the DMA/AXI-Stream interconnect. It hides the fixed BRAM read latency behind a small credit-managed FIFO, so it sustains one beat per cycle when `m_axis_tready` is held high.

## Interface
Parameters:
- `ADDR_W`, `ADDRESS_WIDTH`: BRAM address width.
- `DATA_W`, `DATA_WIDTH` (16): BRAM word and stream beat width.
- `DEPTH`, `DEPTH`: cells per frame. Addresses run 0..DEPTH-1.
- `READ_LAT`, `RAM_READ_WAIT`: cycles from `bram_en` sampled high to `bram_dout` valid. Must be ≥1.
- `FIFO_D`, READ_LAT+2: output FIFO depth.

Ports:
- `clk`: in, 1. Clock.
- `rst`: in, 1. Reset, asynchronous, active-high.
- `start`: in, 1. Single-cycle pulse that begins a frame readout. Ignored while `busy`.
- `busy`: out, 1. High from the cycle after an accepted `start` until `frame_done`.
- `frame_done`: out, 1. One-cycle pulse after the last beat handshakes.
- `bram_addr`: out, ADDR_W. Read address.
- `bram_en`: out, 1. Read strobe. This block never writes.
- `bram_dout`: in, DATA_W. Read data, valid READ_LAT cycles after `bram_en`.
- `m_axis_tdata`: out, DATA_W. Stream data.
- `m_axis_tvalid`: out, 1. Stream valid.
- `m_axis_tready`: in, 1. Stream ready.
- `m_axis_tlast`: out, 1. High on the final beat of the frame.
- `frame_count`: out, 16. Number of completed frames. Wraps at 0xFFFF→0.

## Operation
- States and transitions:
  - IDLE → (HEADER if enabled, else READ) on `start`.
  - HEADER → READ once the header beat is accepted into the FIFO.
  - READ → DRAIN after the issue of address DEPTH-1.
  - DRAIN → DONE when the FIFO and the in-flight read pipeline are both empty.
  - DONE → IDLE unconditionally, pulsing `frame_done` and incrementing `frame_count`.
- Read issue:
  - A read is issued in READ when `fifo_count + inflight + push_pending < FIFO_D`.
  - A read is never issued without guaranteed FIFO space. No overflow is possible, so no data loss.
- Address handling:
  - The address counter starts at 0 and increments by 1 per issued read.
  - It stops after DEPTH-1 and never wraps within a frame.
- Read pipeline:
  - A READ_LAT-deep valid shift register tracks reads in flight.
  - Its output pushes `bram_dout` into the FIFO.
- Output:
  - The FIFO head drives `m_axis_tdata`, and `m_axis_tvalid` = FIFO non-empty.
  - A pop occurs on `tvalid && tready`.
  - Push and pop in the same cycle leave the count unchanged.
- `tlast` is asserted on the beat whose output index equals the final beat. It is tracked by a popped-beat counter, not by address.
- Once `tvalid` is asserted, `tdata`, `tvalid` and `tlast` are held stable until the handshake (AXI rule).
- `start` received while `busy` is dropped. No queuing.

## Timing
- Reset value of every output is 0: `busy`, `frame_done`, `bram_addr`, `bram_en`, `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tlast`, `frame_count`.
- Reset mid-frame:
  - Returns to IDLE immediately.
  - Flushes the FIFO and the in-flight pipeline.
  - Does not increment `frame_count`.
- Data latency, with `tready`=1 and the header disabled:
  - `start` at cycle 0.
  - First `bram_en` at cycle 1.
  - First `tvalid` at cycle 1+READ_LAT+1.
- Throughput with `tready` held high: one beat per cycle. The full frame completes in DEPTH beats. `frame_done` follows 1 cycle after the `tlast` handshake.
- When `tready` is low for N cycles, issue stalls once credits are exhausted. After `tready` returns, streaming resumes with no bubble beyond the FIFO's registered output.
- `busy` deasserts in the same cycle `frame_done` pulses.

## Configuration
- Macro: `LATTICE_READOUT_HEADER_EN`.
- Defined:
  - Each frame is prefixed with one header beat whose `tdata` = `frame_count[DATA_W-1:0]` (value before increment).
  - The frame is DEPTH+1 beats, and `tlast` is still on the final cell.
  - The HEADER state exists, and first `tvalid` comes 1 cycle after `start`.
- Undefined:
  - No HEADER state and exactly DEPTH beats.

## Test plan
- Free-flowing readout: DEPTH=16, READ_LAT=2, BRAM[i]=i+0x100, `tready`=1, `start` → 16 beats 0x100..0x10F on consecutive cycles. `tlast` only on 0x10F. `frame_done` 1 cycle later, `frame_count`=1.
- Backpressure: random `tready` at 30% duty → identical ordered data, no drops or duplicates. `tdata` stable while `tvalid && !tready`. FIFO count never exceeds FIFO_D.
- Busy start: `start` pulses again mid-frame → ignored, exactly 16 beats emitted, `frame_count` increments by 1 only.
- Reset mid-frame: assert `rst` after beat 5 → all outputs 0 next cycle. A new `start` yields a full 16-beat frame from address 0, and `frame_count` is unchanged from its pre-frame value.
- Header, with `LATTICE_READOUT_HEADER_EN` defined: three back-to-back frames → header beats 0x0000, 0x0001, 0x0002, each followed by 16 data beats, with `tlast` on data beat 16.
- Wrap: preload `frame_count`=0xFFFF via repeated frames or force, run one frame → `frame_count`=0x0000.
